spell_trace_ctrl: RTL and testbench

SPELL_TRACE_CTRL -- requirements
Module: spell_trace_ctrl

---
 rtl/spell_trace_ctrl_pkg.sv | 26 ++
 rtl/ir_debounce.sv | 48 ++++
 rtl/spell_trace_ctrl.sv | 147 ++++++++++++++
 tb/tb_spell_trace_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spell_trace_ctrl_pkg.sv
// Shared types and defaults for the spell-trace controller.
package spell_trace_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACE  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  localparam logic [1:0] HOUSE_G = 2'd0;
  localparam logic [1:0] HOUSE_H = 2'd1;
  localparam logic [1:0] HOUSE_S = 2'd2;
  localparam logic [1:0] HOUSE_R = 2'd3;

  localparam int DEF_DEB_FRAMES     = 3;
  localparam int DEF_TIMEOUT_FRAMES = 600;
  localparam int DEF_HOLD_FRAMES    = 120;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// 2-flop synchronizer and frame-rate saturating debounce for the 16 IR boxes.
module ir_debounce
  import spell_trace_ctrl_pkg::*;
#(
  parameter int DEB_FRAMES = DEF_DEB_FRAMES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick_i,
  input  logic [15:0] ir_raw_i,
  output logic [15:0] deb_o
);

  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_FRAMES);

  logic [15:0]   sync1_q, sync2_q;
  logic [CW-1:0] cnt_q [16];
  logic [CW-1:0] cnt_d [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (frame_tick_i) begin
        if (!sync2_q[i])              cnt_d[i] = '0;
        else if (cnt_q[i] != DEB_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= ir_raw_i;
      sync2_q <= sync1_q;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    deb_o = '0;
    for (int i = 0; i < 16; i++) deb_o[i] = (cnt_q[i] == DEB_MAX);
  end

endmodule

// File: rtl/spell_trace_ctrl.sv
// Spell-trace game controller: house select, timed trace against a target pattern, result hold.
//   state     | meaning
//   ST_IDLE   | waiting for house press / start
//   ST_TRACE  | accumulating debounced boxes into ir_out, timer running
//   ST_RESULT | done/success shown, ir_out frozen, hold timer running
module spell_trace_ctrl
  import spell_trace_ctrl_pkg::*;
#(
  parameter int DEB_FRAMES     = DEF_DEB_FRAMES,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
  parameter int HOLD_FRAMES    = DEF_HOLD_FRAMES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [15:0] ir_raw,
  input  logic        R,
  input  logic        S,
  input  logic        G,
  input  logic        H,
  input  logic        start,
  input  logic [15:0] target,
  output logic [15:0] ir_out,
  output logic [1:0]  house_sel,
  output logic        house_valid,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [4:0]  traced_count
);

  localparam int TMAX = (TIMEOUT_FRAMES > HOLD_FRAMES) ? TIMEOUT_FRAMES : HOLD_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_FRAMES);
  localparam logic [TW-1:0] HOLD_LD    = TW'(HOLD_FRAMES);

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [15:0]    ir_q, ir_d, target_q, target_d;
  logic [1:0]     house_sel_q, house_sel_d;
  logic           house_valid_q, house_valid_d;
  logic           success_q, success_d;
  logic [15:0]    deb, ir_next;
  logic           fail_off, hit, expired;

  ir_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick_i (frame_tick),
    .ir_raw_i     (ir_raw),
    .deb_o        (deb)
  );

  // Judge on the mask ir_out is about to take, so a box landing on the expiry frame still counts.
  always_comb begin
    ir_next  = ir_q | deb;
    fail_off = ((ir_next & ~target_q) != 16'd0) || (target_q == 16'd0);
    hit      = (ir_next == target_q);
    expired  = (timer_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start && house_valid_q)      state_d = ST_TRACE;
      ST_TRACE:  if (fail_off || hit || expired)  state_d = ST_RESULT;
      ST_RESULT: if (expired)                     state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_TRACE);
    done = (state_q == ST_RESULT);
  end

  always_comb begin
    ir_d          = ir_q;
    timer_d       = timer_q;
    target_d      = target_q;
    house_sel_d   = house_sel_q;
    house_valid_d = house_valid_q;
    success_d     = success_q;
    case (state_q)
      ST_IDLE: begin
        case ({R, S, H, G})
          4'b0001: begin house_sel_d = HOUSE_G; house_valid_d = 1'b1; end
          4'b0010: begin house_sel_d = HOUSE_H; house_valid_d = 1'b1; end
          4'b0100: begin house_sel_d = HOUSE_S; house_valid_d = 1'b1; end
          4'b1000: begin house_sel_d = HOUSE_R; house_valid_d = 1'b1; end
          default: ;
        endcase
        if (start && house_valid_q) begin
          ir_d     = '0;
          target_d = target;
          timer_d  = TIMEOUT_LD;
        end
      end
      ST_TRACE: begin
        ir_d = ir_next;
        if (frame_tick && !expired) timer_d = timer_q - TW'(1);
        if (state_d == ST_RESULT) begin
          success_d = !fail_off && hit;
          timer_d   = HOLD_LD;
        end
      end
      ST_RESULT: begin
        if (frame_tick && !expired) timer_d = timer_q - TW'(1);
        if (expired) begin
          ir_d      = '0;
          success_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q          <= '0;
      timer_q       <= '0;
      target_q      <= '0;
      house_sel_q   <= '0;
      house_valid_q <= 1'b0;
      success_q     <= 1'b0;
    end else begin
      ir_q          <= ir_d;
      timer_q       <= timer_d;
      target_q      <= target_d;
      house_sel_q   <= house_sel_d;
      house_valid_q <= house_valid_d;
      success_q     <= success_d;
    end
  end

  assign ir_out       = ir_q;
  assign house_sel    = house_sel_q;
  assign house_valid  = house_valid_q;
  assign success      = success_q;
  assign traced_count = popcount16(ir_q);

endmodule

// File: tb/tb_spell_trace_ctrl.sv
// Scoreboard bench for spell_trace_ctrl: results checked on each rising done.
module tb_spell_trace_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [15:0] ir_raw;
  logic        R, S, G, H;
  logic        start;
  logic [15:0] target;
  logic [15:0] ir_out;
  logic [1:0]  house_sel;
  logic        house_valid, busy, done, success;
  logic [4:0]  traced_count;

  typedef struct {
    logic [15:0] ir;
    logic        succ;
    logic [4:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  spell_trace_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .ir_raw       (ir_raw),
    .R            (R),
    .S            (S),
    .G            (G),
    .H            (H),
    .start        (start),
    .target       (target),
    .ir_out       (ir_out),
    .house_sel    (house_sel),
    .house_valid  (house_valid),
    .busy         (busy),
    .done         (done),
    .success      (success),
    .traced_count (traced_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  task automatic push_exp(input logic [15:0] ir, input logic succ, input logic [4:0] cnt);
    exp_t e;
    e.ir = ir; e.succ = succ; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // extra cycles let the value clear the 2-flop synchronizer before the next tick
  task automatic set_ir(input logic [15:0] v);
    @(negedge clk) ir_raw = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] t);
    @(negedge clk) begin target = t; start = 1'b1; end
    @(negedge clk) start = 1'b0;
  endtask

  task automatic press(input logic r, input logic s, input logic g, input logic h);
    @(negedge clk) begin R = r; S = s; G = g; H = h; end
    @(negedge clk) begin R = 0; S = 0; G = 0; H = 0; end
  endtask

  // monitor: every rising done must match the oldest queued expectation
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_result: ir_out=%0h success=%0b with no result expected", ir_out, success);
        end else begin
          e = exp_q.pop_front();
          check("result_ir_out", ir_out, e.ir);
          check("result_success", success, e.succ);
          check("result_traced_count", traced_count, e.cnt);
        end
      end
      prev = done;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; ir_raw = '0;
    R = 0; S = 0; G = 0; H = 0; start = 1'b0; target = '0;
    repeat (2) @(negedge clk);
    check("reset_ir_out", ir_out, 16'h0000);
    check("reset_house_valid", house_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // house selection
    press(1, 0, 0, 0);
    check("house_r_sel", house_sel, 2'd3);
    check("house_r_valid", house_valid, 1'b1);
    press(0, 0, 1, 0);
    check("house_g_sel", house_sel, 2'd0);
    press(1, 1, 0, 0);
    check("house_multi_sel", house_sel, 2'd0);
    check("house_multi_valid", house_valid, 1'b1);

    // success trace, house press and start ignored outside IDLE
    push_exp(16'h000F, 1'b1, 5'd4);
    do_start(16'h000F);
    check("trace_busy", busy, 1'b1);
    press(0, 0, 0, 1);
    check("house_ignored_trace", house_sel, 2'd0);
    set_ir(16'h000F);
    frames(3);
    check("success_done", done, 1'b1);
    check("success_busy", busy, 1'b0);
    do_start(16'h0001);
    frames(119);
    check("hold_119_done", done, 1'b1);
    frames(1);
    check("hold_120_done", done, 1'b0);
    check("hold_120_ir_out", ir_out, 16'h0000);
    check("hold_120_success", success, 1'b0);
    check("hold_120_house_valid", house_valid, 1'b1);
    set_ir(16'h0000);
    frames(1);

    // off-target box 5
    push_exp(16'h0020, 1'b0, 5'd1);
    do_start(16'h000F);
    set_ir(16'h0020);
    frames(3);
    check("offtarget_done", done, 1'b1);
    frames(120);
    check("offtarget_idle", done, 1'b0);
    set_ir(16'h0000);
    frames(1);

    // zero target fails at once
    push_exp(16'h0000, 1'b0, 5'd0);
    do_start(16'h0000);
    repeat (2) @(negedge clk);
    check("zero_target_done", done, 1'b1);
    frames(120);

    // timeout with only box 0
    push_exp(16'h0001, 1'b0, 5'd1);
    do_start(16'h8001);
    set_ir(16'h0001);
    frames(599);
    check("timeout_599_busy", busy, 1'b1);
    frames(1);
    check("timeout_600_done", done, 1'b1);
    frames(120);
    check("timeout_idle_ir_out", ir_out, 16'h0000);

    // box 15 debounces on the same tick the timer expires: success wins
    push_exp(16'h8001, 1'b1, 5'd2);
    do_start(16'h8001);
    frames(597);
    set_ir(16'h8001);
    frames(2);
    check("tosucc_599_busy", busy, 1'b1);
    frames(1);
    check("tosucc_600_done", done, 1'b1);
    frames(120);
    set_ir(16'h0000);
    frames(1);

    // glitch, then reset mid-trace
    press(1, 0, 0, 0);
    do_start(16'h000F);
    set_ir(16'h0001);
    frames(2);
    set_ir(16'h0000);
    frames(2);
    check("glitch_ir_out", ir_out, 16'h0000);
    check("glitch_busy", busy, 1'b1);
    set_ir(16'h0004);
    frames(3);
    check("partial_ir_out", ir_out, 16'h0004);
    check("partial_count", traced_count, 5'd1);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("midreset_ir_out", ir_out, 16'h0000);
    check("midreset_house_sel", house_sel, 2'd0);
    check("midreset_house_valid", house_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_success", success, 1'b0);
    check("midreset_count", traced_count, 5'd0);
    @(negedge clk) reset_n = 1'b1;
    set_ir(16'h0000);
    do_start(16'h000F);
    repeat (2) @(negedge clk);
    check("start_no_house_busy", busy, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
